uart_rx_packer: RTL and testbench

- Receive-side counterpart of the UART TX connector.
- Takes single-byte strobes from the UART RX core and packs 32 consecutive bytes into one 256-bit word.
- Pushes each word into the DDR3 write-data FIFO using the FIFO's full flag as backpressure.
- One holding register decouples word completion from FIFO availability, so the UART keeps streaming while a word waits.

---
 rtl/uart_ddr_pkg.sv | 15 +
 rtl/uart_rx_packer_shifter.sv | 49 ++++
 rtl/uart_rx_packer.sv | 132 +++++++++++++
 tb/tb_uart_rx_packer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_ddr_pkg.sv
// Shared constants and types for the UART <-> DDR3 connector blocks.
package uart_ddr_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 256;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int CNT_W          = 5;
    localparam int TIMEOUT_CYC    = 50000;

    typedef enum logic [0:0] {
        FILL      = 1'b0,
        FULL_WAIT = 1'b1
    } rx_pack_state_t;

endpackage

// File: rtl/uart_rx_packer_shifter.sv
// Byte-lane accumulator: writes each incoming byte into the lane selected by the
// running count, so byte n of a word lands in bits [8n+7:8n].
module rx_word_shifter
    import uart_ddr_pkg::*;
#(
    parameter int N_BYTES = BYTES_PER_WORD
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [BYTE_W-1:0]         wr_data,
    input  logic                      clear,
    output logic [N_BYTES*BYTE_W-1:0] acc,
    output logic [CNT_W-1:0]          byte_cnt,
    output logic                      complete
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cnt_reg <= '0;
        end else if (wr_en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Lanes are cleared together so a flushed partial word carries zero upper bytes.
    genvar gi;
    generate
        for (gi = 0; gi < N_BYTES; gi++) begin : g_lane
            logic [BYTE_W-1:0] lane_reg;

            always_ff @(posedge clk) begin
                if (!reset || clear) begin
                    lane_reg <= '0;
                end else if (wr_en && (cnt_reg == CNT_W'(gi))) begin
                    lane_reg <= wr_data;
                end
            end

            assign acc[gi*BYTE_W +: BYTE_W] = lane_reg;
        end
    endgenerate

    assign byte_cnt = cnt_reg;
    assign complete = (cnt_reg == CNT_W'(N_BYTES - 1));

endmodule

// File: rtl/uart_rx_packer.sv
// Packs UART RX bytes into 256-bit words and pushes them to the DDR3 write FIFO.
// Optional idle flush of partial words: define UART_RX_PACK_TIMEOUT_FLUSH_EN.
module uart_rx_packer
    import uart_ddr_pkg::*;
#(
    parameter int BYTES_PER_WORD = uart_ddr_pkg::BYTES_PER_WORD,
    parameter int TIMEOUT_CYC    = uart_ddr_pkg::TIMEOUT_CYC
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_rx_valid,
    input  logic [BYTE_W-1:0]            i_rx_data,
    input  logic                         i_fifo_full,
    output logic                         o_wr_en,
    output logic [BYTES_PER_WORD*BYTE_W-1:0] o_wr_data,
    output logic [CNT_W-1:0]             o_byte_cnt,
    output logic [7:0]                   o_word_cnt,
    output logic                         o_overrun
);

    localparam int W = BYTES_PER_WORD * BYTE_W;

    rx_pack_state_t state_reg, state_next;
    logic [W-1:0]   hold_reg, hold_next;
    logic           pending_reg, pending_next;
    logic [7:0]     word_cnt_reg, word_cnt_next;
    logic           overrun_reg, overrun_next;

    logic [W-1:0]   acc;
    logic           complete;
    logic           hold_free;
    logic           load;
    logic           drop;
    logic           flush;
    logic           shift_wr;

    rx_word_shifter #(
        .N_BYTES (BYTES_PER_WORD)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (shift_wr),
        .wr_data  (i_rx_data),
        .clear    (load | flush),
        .acc      (acc),
        .byte_cnt (o_byte_cnt),
        .complete (complete)
    );

    assign o_wr_en   = pending_reg & ~i_fifo_full;
    // A register being drained this cycle can be refilled on the same edge.
    assign hold_free = ~pending_reg | o_wr_en;
    assign shift_wr  = i_rx_valid & ~complete;
    assign load      = i_rx_valid & complete & hold_free;
    assign drop      = i_rx_valid & complete & ~hold_free;

`ifdef UART_RX_PACK_TIMEOUT_FLUSH_EN
    logic [15:0] idle_reg, idle_next;
    logic        timed_out;

    assign timed_out = (idle_reg == 16'(TIMEOUT_CYC));
    assign flush     = timed_out & hold_free & ~i_rx_valid & (o_byte_cnt != '0);

    always_comb begin
        idle_next = idle_reg;
        if (i_rx_valid || flush) begin
            idle_next = '0;
        end else if ((o_byte_cnt != '0) && !timed_out) begin
            idle_next = idle_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idle_reg <= '0;
        end else begin
            idle_reg <= idle_next;
        end
    end
`else
    assign flush = 1'b0;

    // Keeps the timeout parameter meaningful in builds without the flush.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_timeout_out_of_range
    end
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL:      if (drop) state_next = FULL_WAIT;
            FULL_WAIT: if (load || flush) state_next = FILL;
            default:   state_next = FILL;
        endcase
    end

    always_comb begin
        hold_next     = hold_reg;
        pending_next  = pending_reg & ~o_wr_en;
        word_cnt_next = word_cnt_reg + {7'd0, o_wr_en};
        overrun_next  = overrun_reg | drop;
        // Lane 31 is never written by the shifter, so OR-ing in the last byte is exact.
        if (load) begin
            hold_next    = acc | {i_rx_data, {(W-BYTE_W){1'b0}}};
            pending_next = 1'b1;
        end else if (flush) begin
            hold_next    = acc;
            pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= FILL;
            hold_reg     <= '0;
            pending_reg  <= 1'b0;
            word_cnt_reg <= '0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_reg     <= hold_next;
            pending_reg  <= pending_next;
            word_cnt_reg <= word_cnt_next;
            overrun_reg  <= overrun_next;
        end
    end

    assign o_wr_data  = hold_reg;
    assign o_word_cnt = word_cnt_reg;
    assign o_overrun  = overrun_reg;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Scoreboard bench for uart_rx_packer: expected words are queued as bytes are sent
// and compared whenever the DUT writes to the FIFO.
module tb_uart_rx_packer;

    localparam int TB_TIMEOUT = 60;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_rx_valid;
    logic [7:0]   i_rx_data;
    logic         i_fifo_full;
    logic         o_wr_en;
    logic [255:0] o_wr_data;
    logic [4:0]   o_byte_cnt;
    logic [7:0]   o_word_cnt;
    logic         o_overrun;

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    logic [255:0] sb[$];

    uart_rx_packer #(
        .BYTES_PER_WORD (32),
        .TIMEOUT_CYC    (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_rx_valid  (i_rx_valid),
        .i_rx_data   (i_rx_data),
        .i_fifo_full (i_fifo_full),
        .o_wr_en     (o_wr_en),
        .o_wr_data   (o_wr_data),
        .o_byte_cnt  (o_byte_cnt),
        .o_word_cnt  (o_word_cnt),
        .o_overrun   (o_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && o_wr_en) begin
            wr_seen++;
            $display("wr %0d data %h", wr_seen, o_wr_data);
            if (sb.size() == 0) begin
                check("unexpected_wr", 256'd1, 256'd0);
            end else begin
                logic [255:0] exp_word;
                exp_word = sb.pop_front();
                check("wr_data", o_wr_data, exp_word);
            end
        end
    end

    // Called at posedge+1; leaves valid high if the next call follows immediately.
    task automatic send_byte(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(posedge clk); #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [255:0] w0, w1;
        int base;

        reset = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_data = 8'h00;
        i_fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", o_wr_en, 0);
        check("rst_wr_data", o_wr_data, 0);
        check("rst_byte_cnt", o_byte_cnt, 0);
        check("rst_word_cnt", o_word_cnt, 0);
        check("rst_overrun", o_overrun, 0);
        reset = 1'b1;
        idle(1);

        // Single word 0x00..0x1F with latency check
        for (int i = 0; i < 32; i++) w0[8*i +: 8] = 8'(i);
        sb.push_back(w0);
        base = wr_seen;
        for (int i = 0; i < 31; i++) send_byte(8'(i));
        check("t1_cnt31", o_byte_cnt, 31);
        send_byte(8'h1F);
        check("t1_latency", o_wr_en, 1);
        idle(3);
        check("t1_writes", 256'(wr_seen - base), 1);
        check("t1_word_cnt", o_word_cnt, 1);
        check("t1_byte_cnt", o_byte_cnt, 0);

        // Same word held by full for 10 cycles
        base = wr_seen;
        sb.push_back(w0);
        i_fifo_full = 1'b1;
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t2_hold_wr_en", o_wr_en, 0);
            check("t2_hold_data", o_wr_data, w0);
            @(posedge clk); #1;
        end
        i_fifo_full = 1'b0;
        idle(3);
        check("t2_writes", 256'(wr_seen - base), 1);
        check("t2_word_cnt", o_word_cnt, 2);

        // 64 bytes with full throughout -> overrun, one byte dropped
        base = wr_seen;
        for (int i = 0; i < 32; i++) w0[8*i +: 8] = 8'(8'h40 + i);
        for (int i = 0; i < 31; i++) w1[8*i +: 8] = 8'(8'h60 + i);
        w1[255:248] = 8'h80;
        sb.push_back(w0);
        sb.push_back(w1);
        i_fifo_full = 1'b1;
        for (int i = 0; i < 64; i++) send_byte(8'(8'h40 + i));
        idle(1);
        check("t3_overrun", o_overrun, 1);
        check("t3_byte_cnt", o_byte_cnt, 31);
        check("t3_no_write", 256'(wr_seen - base), 0);
        i_fifo_full = 1'b0;
        idle(3);
        check("t3_word0_written", 256'(wr_seen - base), 1);
        send_byte(8'h80);
        idle(3);
        check("t3_word1_written", 256'(wr_seen - base), 2);
        check("t3_overrun_sticky", o_overrun, 1);
        check("t3_word_cnt", o_word_cnt, 4);

        // Reset mid-word discards partial bytes
        for (int i = 0; i < 10; i++) send_byte(8'(8'hE0 + i));
        do_reset();
        check("t4_rst_byte_cnt", o_byte_cnt, 0);
        check("t4_rst_overrun", o_overrun, 0);
        check("t4_rst_word_cnt", o_word_cnt, 0);
        base = wr_seen;
        for (int i = 0; i < 32; i++) w0[8*i +: 8] = 8'(8'hA0 + i);
        sb.push_back(w0);
        for (int i = 0; i < 32; i++) send_byte(8'(8'hA0 + i));
        idle(3);
        check("t4_writes", 256'(wr_seen - base), 1);
        check("t4_word_cnt", o_word_cnt, 1);

        // 256 back-to-back words: word counter wraps
        do_reset();
        base = wr_seen;
        for (int w = 0; w < 256; w++) begin
            for (int i = 0; i < 32; i++) w0[8*i +: 8] = 8'($urandom_range(0, 255));
            sb.push_back(w0);
            for (int i = 0; i < 32; i++) send_byte(w0[8*i +: 8]);
        end
        idle(3);
        check("t5_writes", 256'(wr_seen - base), 256);
        check("t5_word_cnt_wrap", o_word_cnt, 0);
        check("t5_no_overrun", o_overrun, 0);

`ifdef UART_RX_PACK_TIMEOUT_FLUSH_EN
        // Idle flush of a 5-byte partial word
        base = wr_seen;
        w0 = '0;
        for (int i = 0; i < 5; i++) w0[8*i +: 8] = 8'(8'h11 + i);
        sb.push_back(w0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i));
        check("t6_partial_cnt", o_byte_cnt, 5);
        idle(TB_TIMEOUT + 20);
        check("t6_writes", 256'(wr_seen - base), 1);
        check("t6_byte_cnt", o_byte_cnt, 0);
`endif

        idle(2);
        check("sb_empty", 256'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
